// File: rtl/shift_left_1.sv
// Shift-left-by-one with a 2-entry in-order result buffer and valid/ready handshakes on both sides.
// Optional carry_out/overflow flag outputs are compiled in when SHL1_FLAGS_EN is defined.
module shift_left_1 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SHL1_FLAGS_EN
  ,
  output logic             carry_out,
  output logic             overflow
`endif
);

`ifdef SHL1_FLAGS_EN
  localparam int ENT_W = WIDTH + 2;
`else
  localparam int ENT_W = WIDTH;
`endif

  function automatic logic [WIDTH-1:0] shl1(input logic [WIDTH-1:0] v);
    return v << 1;
  endfunction

`ifdef SHL1_FLAGS_EN
  // Entry layout: {carry, overflow, data}; flags come from the operand before shifting.
  function automatic logic [ENT_W-1:0] make_entry(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v[WIDTH-1] ^ v[WIDTH-2], shl1(v)};
  endfunction
`else
  function automatic logic [ENT_W-1:0] make_entry(input logic [WIDTH-1:0] v);
    return shl1(v);
  endfunction
`endif

  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             accept;
  logic             deliver;
  logic [ENT_W-1:0] ent_p0;
  logic [ENT_W-1:0] ent_p1;
  logic [ENT_W-1:0] ent_new;

  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign ent_new   = make_entry(in);

  always_comb begin
    count_nxt = count;
    case ({accept, deliver})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
    end
  end

  // Buffer stage: ent_p0 is the oldest entry; a new entry lands in the slot just past the survivors.
  always_ff @(posedge clk) begin
    if (deliver)
      ent_p0 <= ent_p1;
    if (accept) begin
      if (count_nxt == 2'd1)
        ent_p0 <= ent_new;
      else
        ent_p1 <= ent_new;
    end
  end

  // Output stage: contents are don't-care when empty, so everything is gated by out_valid.
  assign out = out_valid ? ent_p0[WIDTH-1:0] : '0;
`ifdef SHL1_FLAGS_EN
  assign carry_out = out_valid ? ent_p0[WIDTH+1] : 1'b0;
  assign overflow  = out_valid ? ent_p0[WIDTH]   : 1'b0;
`endif

endmodule

// File: tb/tb_shift_left_1.sv
// Randomized bench for shift_left_1 (WIDTH=64) against a queue-based reference model.
// Flag outputs are checked when SHL1_FLAGS_EN is defined.
module tb_shift_left_1;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
`ifdef SHL1_FLAGS_EN
  logic         carry_out;
  logic         overflow;
`endif

  shift_left_1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SHL1_FLAGS_EN
    ,
    .carry_out (carry_out),
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    logic         o;
  } ent_t;

  ent_t q[$];
  logic rdy_m;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: doubling modulo 2^W; carry when the unsigned operand is >= 2^(W-1);
  // overflow when the signed doubling leaves the signed W-bit range.
  function automatic ent_t ref_shift(input logic [W-1:0] d);
    ent_t r;
    logic signed [W-1:0] s;
    s   = d;
    r.d = d * 2;
    r.c = (d >= 64'h8000_0000_0000_0000);
    r.o = (s > 64'sh3FFF_FFFF_FFFF_FFFF) || (s < -64'sh4000_0000_0000_0000);
    return r;
  endfunction

  // One clock: check outputs at negedge, then advance the model across the posedge.
  task automatic cycle(output bit acc);
    bit           del;
    logic [W-1:0] din;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, rdy_m);
    chk("out", out, (q.size() > 0) ? q[0].d : '0);
`ifdef SHL1_FLAGS_EN
    chk("carry_out", carry_out, (q.size() > 0) ? q[0].c : 1'b0);
    chk("overflow", overflow, (q.size() > 0) ? q[0].o : 1'b0);
`endif
    acc = in_valid && rdy_m;
    del = (q.size() > 0) && out_ready;
    din = in;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      rdy_m = 1'b0;
      acc   = 1'b0;
    end else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back(ref_shift(din));
      rdy_m = (q.size() < 2);
    end
    #1;
  endtask

  function automatic logic [W-1:0] rand_data();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h4000_0000_0000_0000;
      4:       return 64'hC000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    bit           a;
    int           k;
    int           nb;
    logic [W-1:0] vals [3];

    rst_n     = 1'b0;
    in        = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rdy_m = 1'b0;
    cycle(a);
    rst_n = 1'b1;
    cycle(a);

    // Directed shift values
    in = 64'h0FF9; in_valid = 1'b1; out_ready = 1'b1;
    cycle(a);
    chk("r028_out", out, 64'h0000_0000_0000_1FF2);
    chk("r028_valid", out_valid, 1'b1);
`ifdef SHL1_FLAGS_EN
    chk("r028_carry", carry_out, 1'b0);
    chk("r028_ovf", overflow, 1'b0);
`endif
    in = 64'h6A9A;
    cycle(a);
    chk("r029_out_a", out, 64'h0000_0000_0000_D534);
    in = 64'h8000_0000_0000_0001;
    cycle(a);
    chk("r029_out_b", out, 64'h0000_0000_0000_0002);
`ifdef SHL1_FLAGS_EN
    chk("r029_carry", carry_out, 1'b1);
    chk("r029_ovf", overflow, 1'b1);
`endif
    in_valid = 1'b0;
    repeat (2) cycle(a);

    // Backpressure: three offered with out_ready low
    for (int i = 0; i < 3; i++) vals[i] = {$urandom, $urandom};
    out_ready = 1'b0; in_valid = 1'b1; k = 0;
    for (int i = 0; i < 4; i++) begin
      in = vals[k];
      cycle(a);
      if (a) k++;
    end
    chk("r030_accepted", k, 2);
    chk("r030_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (k < 3);
      in       = vals[(k < 3) ? k : 2];
      cycle(a);
      if (a) k++;
    end
    chk("r030_third", k, 3);

    // Streaming: no bubbles after the first result
    in_valid = 1'b1; out_ready = 1'b1; nb = 0;
    in = rand_data();
    for (int i = 0; i < 20; i++) begin
      cycle(a);
      if (a) in = rand_data();
      if (!out_valid) nb++;
    end
    chk("r031_bubbles", nb, 0);

    // Reset with a full buffer
    in_valid = 1'b0;
    repeat (2) cycle(a);
    out_ready = 1'b0; in_valid = 1'b1;
    in = rand_data(); cycle(a);
    in = rand_data(); cycle(a);
    chk("r032_full", in_ready, 1'b0);
    rst_n = 1'b0;
    cycle(a);
    chk("r032_valid", out_valid, 1'b0);
    chk("r032_out", out, '0);
    rst_n = 1'b1; in_valid = 1'b0;
    cycle(a);
    chk("r032_ready", in_ready, 1'b1);

    // Random traffic with occasional resets
    in = rand_data();
    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 60) != 0);
      cycle(a);
      if (a || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in       = rand_data();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/shift_left_1.md
SHIFT_LEFT_1 -- requirements
Module: shift_left_1

Interface
REQ-001 SHALL have parameter: WIDTH, default 64, data width in bits (legal range 2..128).
REQ-002 SHALL use a single clock and a synchronous, active-low reset.
REQ-003 SHALL have port: clk  input  1  rising-edge clock; the only clock in the block.
REQ-004 SHALL have port: rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port: in  input  WIDTH  operand to shift.
REQ-006 SHALL have port: in_valid  input  1  high when the value on in is offered.
REQ-007 SHALL have port: in_ready  output  1  high when an offered input can be accepted; driven from a register.
REQ-008 SHALL have port: out  output  WIDTH  shifted result.
REQ-009 SHALL have port: out_valid  output  1  high when out holds a result.
REQ-010 SHALL have port: out_ready  input  1  downstream consumer accepts out.
REQ-011 SHALL have port: carry_out  output  1  bit shifted out of the MSB; present only when SHL1_FLAGS_EN is defined.
REQ-012 SHALL have port: overflow  output  1  signed-overflow flag; present only when SHL1_FLAGS_EN is defined.

Function
REQ-013 SHALL compute out = {in[WIDTH-2:0], 1'b0}: a logical shift left by one, with the LSB forced to 0 and in[WIDTH-1] discarded.
REQ-014 SHALL accept an input on a rising edge where in_valid && in_ready, and deliver a result on a rising edge where out_valid && out_ready.
REQ-015 SHALL have a latency of 1 cycle: a result accepted at edge N is presented with out_valid=1 after edge N.
REQ-016 SHALL hold results in a 2-entry in-order buffer; entry count C is in {0,1,2}; out shows the oldest entry.
REQ-017 SHALL register in_ready = (C<2) for the next cycle; while C=2, in_ready=0 and in_valid is ignored.
REQ-018 SHALL handle simultaneous accept and delivery as follows: C is unchanged, the oldest entry is removed, and the new result is appended; at C=1 this sustains 1 result per cycle.
REQ-019 SHALL hold out, the flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL drive out_valid=0 when C=0, with out and the flags at 0.
REQ-021 SHALL give the shift no arithmetic rules beyond REQ-013: no sign extension and no saturation, and an all-zero input gives an all-zero output.

Reset
REQ-022 SHALL, on a clk edge with rst_n=0, set C=0, out_valid=0, out=0, carry_out=0, overflow=0, and in_ready=0.
REQ-023 SHALL raise in_ready to 1 on the first edge with rst_n=1.
REQ-024 SHALL discard all buffered results on a reset asserted mid-operation, with no output delivered for them.

Configuration
REQ-025 SHALL compile the flag outputs in only when macro SHL1_FLAGS_EN is defined.
REQ-026 SHALL, with SHL1_FLAGS_EN defined, set carry_out = in[WIDTH-1] and overflow = in[WIDTH-1] ^ in[WIDTH-2], both stored with each entry and aligned with out.
REQ-027 SHALL, without SHL1_FLAGS_EN, omit the carry_out and overflow ports and their storage, leaving all other behaviour identical.

Verification
REQ-028 SHALL be verified with: in=64'h0FF9, in_valid=1, out_ready=1 -> next cycle out=64'h1FF2, out_valid=1, carry_out=0, overflow=0.
REQ-029 SHALL be verified with: in=64'h6A9A -> out=64'hD534; in=64'h8000_0000_0000_0001 -> out=64'h2, carry_out=1, overflow=1.
REQ-030 SHALL be verified with: out_ready=0 while 3 inputs are offered back-to-back -> 2 accepted, in_ready=0, third held; after out_ready=1, results delivered in order.
REQ-031 SHALL be verified with: continuous in_valid=1 and out_ready=1 -> one result every cycle after the first, with no bubbles.
REQ-032 SHALL be verified with: rst_n=0 asserted with C=2 -> next cycle out_valid=0, out=0; after release, in_ready=1.
REQ-033 SHALL be verified with: the bench built without SHL1_FLAGS_EN -> out values identical to REQ-028 and REQ-029.
